// File: rtl/beep_pkg.sv
// Shared state encoding and default timing for the audible-feedback beep player.
package beep_pkg;

  localparam int unsigned DEF_HALF_BASE = 50000;
  localparam int unsigned DEF_BEEP_CYC  = 20000000;
  localparam int unsigned DEF_GAP_CYC   = 15000000;
  localparam int unsigned DEF_CW        = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEEP = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/beep_player_if.sv
// Request/status bundle between top-level control (master) and the beep player (slave).
interface beep_player_if;

  logic       start;
  logic [1:0] count;
  logic [1:0] tone_sel;
  logic       stop;
  logic       BUZZ;
  logic       busy;
  logic       done;
  logic [1:0] beep_idx;

  modport master (
    output start, count, tone_sel, stop,
    input  BUZZ, busy, done, beep_idx
  );

  modport slave (
    input  start, count, tone_sel, stop,
    output BUZZ, busy, done, beep_idx
  );

endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: starts high on the first run cycle, toggles every `half` cycles,
// and sits at 0 with a cleared counter whenever run is low.
module tone_gen #(
  parameter int unsigned CW = 32
) (
  input  logic          CLK,
  input  logic          ena,
  input  logic          run,
  input  logic [CW-1:0] half,
  output logic          wave
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wave_q, wave_d;
  logic          run_q;

  always_comb begin
    cnt_d  = '0;
    wave_d = 1'b0;
    if (run) begin
      // A rising run restarts the tone so every beep begins on a high half-period.
      if (!run_q) begin
        cnt_d  = '0;
        wave_d = 1'b1;
      end else if (cnt_q == half - ONE) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d  = cnt_q + ONE;
        wave_d = wave_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge ena) begin
    if (!ena) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
      run_q  <= run;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/beep_player.sv
// Plays a burst of 0-3 beeps separated by silent gaps, then pulses done.
// Owns the FSM, the shared beep/gap duration counter and the beep index.
module beep_player
  import beep_pkg::*;
#(
  parameter int unsigned HALF_BASE = DEF_HALF_BASE,
  parameter int unsigned BEEP_CYC  = DEF_BEEP_CYC,
  parameter int unsigned GAP_CYC   = DEF_GAP_CYC,
  parameter int unsigned CW        = DEF_CW
) (
  input  logic          CLK,
  input  logic          ena,
  beep_player_if.slave  bus
);

  localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] HB        = CW'(HALF_BASE);
  localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] dur_q, dur_d;
  logic [CW-1:0] half_q, half_d;
  logic [CW-1:0] half_raw;
  logic [1:0]    count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          buzz;

  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    half_d   = half_q;
    count_d  = count_q;
    idx_d    = idx_q;
    half_raw = HB >> bus.tone_sel;
    case (state_q)
      S_IDLE: begin
        // A simultaneous stop discards the start.
        if (bus.start && !bus.stop) begin
          idx_d   = 2'd0;
          dur_d   = '0;
          count_d = bus.count;
          half_d  = (half_raw == '0) ? ONE : half_raw;
          state_d = (bus.count == 2'd0) ? S_DONE : S_BEEP;
        end
      end
      S_BEEP: begin
        if (bus.stop) begin
          dur_d   = '0;
          state_d = S_IDLE;
        end else if (dur_q == BEEP_LAST) begin
          dur_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q + 2'd1 == count_q) ? S_DONE : S_GAP;
        end else begin
          dur_d = dur_q + ONE;
        end
      end
      S_GAP: begin
        if (bus.stop) begin
          dur_d   = '0;
          state_d = S_IDLE;
        end else if (dur_q == GAP_LAST) begin
          dur_d   = '0;
          state_d = S_BEEP;
        end else begin
          dur_d = dur_q + ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        dur_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge ena) begin
    if (!ena) begin
      state_q <= S_IDLE;
      dur_q   <= '0;
      half_q  <= '0;
      count_q <= 2'd0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Driven from the next state so the tone register is already high in the first BEEP cycle.
  tone_gen #(.CW(CW)) u_tone (
    .CLK  (CLK),
    .ena  (ena),
    .run  (state_d == S_BEEP),
    .half (half_q),
    .wave (buzz)
  );

  assign bus.BUZZ     = buzz;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.beep_idx = idx_q;

endmodule

// File: tb/tb_beep_player.sv
// Self-checking bench for beep_player: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a schedule-based model.
module tb_beep_player;

  localparam int HB = 4;
  localparam int BC = 16;
  localparam int GC = 8;

  logic clk = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  beep_player_if bus ();

  beep_player #(
    .HALF_BASE (HB),
    .BEEP_CYC  (BC),
    .GAP_CYC   (GC),
    .CW        (32)
  ) dut (
    .CLK (clk),
    .ena (ena),
    .bus (bus)
  );

  typedef struct {
    logic       buzz;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } exp_t;

  exp_t cur;
  exp_t pend[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic bz, input logic bs, input logic dn, input logic [1:0] ix);
    exp_t e;
    e.buzz = bz;
    e.busy = bs;
    e.done = dn;
    e.idx  = ix;
    return e;
  endfunction

  // Expand a whole accepted burst into its per-cycle output sequence.
  task automatic build(input logic [1:0] cnt, input logic [1:0] sel);
    int half;
    int c;
    c    = int'(cnt);
    half = HB >> sel;
    if (half == 0) half = 1;
    pend.delete();
    for (int b = 0; b < c; b++) begin
      for (int t = 0; t < BC; t++) pend.push_back(mk(((t / half) % 2) == 0, 1'b1, 1'b0, 2'(b)));
      if (b != c - 1)
        for (int g = 0; g < GC; g++) pend.push_back(mk(1'b0, 1'b1, 1'b0, 2'(b + 1)));
    end
    pend.push_back(mk(1'b0, 1'b1, 1'b1, cnt));
  endtask

  task automatic model_reset();
    cur = mk(1'b0, 1'b0, 1'b0, 2'd0);
    pend.delete();
  endtask

  task automatic model_update();
    if (!ena) begin
      model_reset();
    end else if (cur.busy) begin
      if (bus.stop) begin
        cur = mk(1'b0, 1'b0, 1'b0, cur.idx);
        pend.delete();
      end else if (pend.size() > 0) begin
        cur = pend.pop_front();
      end else begin
        cur = mk(1'b0, 1'b0, 1'b0, cur.idx);
      end
    end else if (bus.start && !bus.stop) begin
      build(bus.count, bus.tone_sel);
      cur = pend.pop_front();
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic compare();
    checkOutput("cycle {buzz,busy,done,idx}",
                32'({bus.BUZZ, bus.busy, bus.done, bus.beep_idx}),
                32'({cur.buzz, cur.busy, cur.done, cur.idx}));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] c, input logic [1:0] ts, input logic sp);
    bus.start    = s;
    bus.count    = c;
    bus.tone_sel = ts;
    bus.stop     = sp;
    step();
  endtask

  initial begin
    logic [15:0] seen;
    logic [3:0]  seen4;
    int          busy_n;
    int          done_n;
    int          done_at;

    bus.start    = 1'b0;
    bus.count    = 2'd0;
    bus.tone_sel = 2'd0;
    bus.stop     = 1'b0;
    model_reset();

    $display("[TB] reset hold");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[0], 2'd3, 2'd0, 1'b0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    end
    ena = 1'b1;
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0);
    checkOutput("post_reset_idle", 32'({bus.BUZZ, bus.busy, bus.done, bus.beep_idx}), 32'd0);

    $display("[TB] single beep, tone_sel 0");
    seen = '0; busy_n = 0; done_at = 0;
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(i == 1, 2'd1, 2'd0, 1'b0);
      if (i <= 16) seen[16 - i] = bus.BUZZ;
      if (bus.busy) busy_n++;
      if (bus.done) done_at = i;
    end
    checkOutput("c1_buzz_pattern", 32'(seen), 32'h0000_F0F0);
    checkOutput("c1_busy_cycles", 32'(busy_n), 32'd17);
    checkOutput("c1_done_cycle", 32'(done_at), 32'd17);
    checkOutput("c1_busy_end", 32'(bus.busy), 32'd0);
    checkOutput("c1_beep_idx", 32'(bus.beep_idx), 32'd1);

    $display("[TB] three beeps");
    busy_n = 0; done_n = 0; done_at = 0;
    for (int i = 1; i <= 70; i++) begin
      applyStimulus(i == 1, 2'd3, 2'd0, 1'b0);
      if (bus.busy) busy_n++;
      if (bus.done) begin done_n++; done_at = i; end
    end
    checkOutput("c3_busy_cycles", 32'(busy_n), 32'd65);
    checkOutput("c3_done_count", 32'(done_n), 32'd1);
    checkOutput("c3_done_cycle", 32'(done_at), 32'd65);
    checkOutput("c3_beep_idx", 32'(bus.beep_idx), 32'd3);

    $display("[TB] zero beeps");
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0);
    checkOutput("c0_first", 32'({bus.BUZZ, bus.busy, bus.done, bus.beep_idx}), 32'b0_1_1_00);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0);
    checkOutput("c0_second", 32'({bus.BUZZ, bus.busy, bus.done}), 32'd0);

    for (int ts = 2; ts <= 3; ts++) begin
      $display("[TB] fast tone, tone_sel %0d", ts);
      seen4 = '0;
      for (int i = 1; i <= 20; i++) begin
        applyStimulus(i == 1, 2'd1, 2'(ts), 1'b0);
        if (i <= 4) seen4[4 - i] = bus.BUZZ;
      end
      checkOutput("fast_buzz_pattern", 32'(seen4), 32'b1010);
    end

    $display("[TB] start during beep ignored");
    busy_n = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(i == 1 || i == 3, (i == 1) ? 2'd1 : 2'd3, 2'd1, 1'b0);
      if (bus.busy) busy_n++;
    end
    checkOutput("ign_busy_cycles", 32'(busy_n), 32'd17);
    checkOutput("ign_beep_idx", 32'(bus.beep_idx), 32'd1);

    $display("[TB] stop in second beep");
    for (int i = 1; i <= 29; i++) applyStimulus(i == 1, 2'd3, 2'd0, 1'b0);
    checkOutput("stop_pre_busy", 32'(bus.busy), 32'd1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1);
    checkOutput("stop_outputs", 32'({bus.BUZZ, bus.busy, bus.done, bus.beep_idx}), 32'b0_0_0_01);
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 2'd0, 2'd0, 1'b0);
      if (bus.done) done_n++;
    end
    checkOutput("stop_no_done", 32'(done_n), 32'd0);

    $display("[TB] reset mid-gap");
    for (int i = 1; i <= 20; i++) applyStimulus(i == 1, 2'd2, 2'd0, 1'b0);
    checkOutput("gap_pre_idx", 32'(bus.beep_idx), 32'd1);
    #2;
    ena = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset_outputs", 32'({bus.BUZZ, bus.busy, bus.done, bus.beep_idx}), 32'd0);
    applyStimulus(1'b1, 2'd2, 2'd0, 1'b0);
    ena = 1'b1;
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      ena = 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        ena = 1'b0;
        #1;
        model_reset();
        compare();
      end
      applyStimulus($urandom_range(0, 3) == 0,
                    2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)),
                    $urandom_range(0, 59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
